hex_seq: RTL and testbench

Parametrised successor to the 4-digit `hex` display block. Converts a `DIGITS`-nibble hex value into TM1637 seven-segment codes and drives the full three-frame TM1637 command sequence (data command, address plus digit bytes, display control) through the existing byte-level TM1637 driver. Adds per-digit decimal points, runtime brightness and display on/off control, and optional leading-zero blanking. Sits between application logic and the byte driver that owns `scl`/`sda`.

---
 rtl/hex_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_hex_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_seq.sv
// hex_seq: DIGITS-nibble hex value to TM1637 seven-segment bytes, issued as the
// three-frame TM1637 command sequence. Optional HEX_SEQ_LEADING_BLANK_EN blanks leading zeros.
module hex_seq #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [2:0]            bright_in,
  input  logic                  disp_on,
  input  logic                  data_latch,
  output logic                  busy,
  output logic [7:0]            tm_byte,
  output logic                  tm_start,
  output logic                  tm_stop,
  output logic                  tm_latch,
  input  logic                  tm_busy
);

  localparam int unsigned DW    = 4 * DIGITS;
  localparam int unsigned CW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned NSLOT = 2 ** CW;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  typedef enum logic [2:0] {IDLE, CMD1, ADDR, DATA, CMD3, WAIT} state_t;

  state_t        state, state_nx;
  state_t        last, last_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          skip, skip_nx;
  logic          pend, pend_nx;
  logic          capture;

  logic [DW-1:0]     data_q;
  logic [DIGITS-1:0] dp_q;
  logic [2:0]        bright_q;
  logic              on_q;

  logic [7:0] byte_d;
  logic       start_d, stop_d, latch_d, busy_d;

  logic [3:0] nib      [DIGITS];
  logic       blank    [DIGITS];
  logic [7:0] dig_byte [NSLOT];

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Per-digit segment bytes from the captured value; digit 0 is the leftmost nibble.
`ifdef HEX_SEQ_LEADING_BLANK_EN
  logic lead [DIGITS];
`endif
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    localparam int unsigned SH = 4 * (DIGITS - 1 - g);
    assign nib[g] = data_q[SH +: 4];
`ifdef HEX_SEQ_LEADING_BLANK_EN
    if (g == 0) begin : g_first
      assign lead[g] = (nib[g] == 4'h0);
    end else begin : g_rest
      assign lead[g] = lead[g-1] && (nib[g] == 4'h0);
    end
    if (g == DIGITS - 1) begin : g_last
      assign blank[g] = 1'b0;
    end else begin : g_lead
      assign blank[g] = lead[g];
    end
`else
    assign blank[g] = 1'b0;
`endif
    assign dig_byte[g] = {dp_q[DIGITS-1-g], blank[g] ? 7'h00 : seg7(nib[g])};
  end

  for (genvar g = DIGITS; g < NSLOT; g++) begin : g_pad
    assign dig_byte[g] = 8'h00;
  end

  // State register plus sequencing context.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= IDLE;
      cnt   <= '0;
      skip  <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
      skip  <= skip_nx;
      pend  <= pend_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= '0;
      dp_q     <= '0;
      bright_q <= '0;
      on_q     <= 1'b0;
    end else if (capture) begin
      data_q   <= data_in;
      dp_q     <= dp_in;
      bright_q <= bright_in;
      on_q     <= disp_on;
    end
  end

  // Next state: capture cycle in IDLE, one cycle per issuing state, WAIT skips one then tracks tm_busy.
  always_comb begin
    state_nx = state;
    last_nx  = last;
    cnt_nx   = cnt;
    skip_nx  = skip;
    pend_nx  = pend;
    capture  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend) begin
          state_nx = CMD1;
          pend_nx  = 1'b0;
          cnt_nx   = '0;
        end else if (data_latch) begin
          capture = 1'b1;
          pend_nx = 1'b1;
        end
      end
      CMD1, ADDR, DATA, CMD3: begin
        last_nx  = state;
        state_nx = WAIT;
        skip_nx  = 1'b1;
      end
      WAIT: begin
        if (skip) begin
          skip_nx = 1'b0;
        end else if (!tm_busy) begin
          unique case (last)
            CMD1: state_nx = ADDR;
            ADDR: begin
              state_nx = DATA;
              cnt_nx   = '0;
            end
            DATA: begin
              if (cnt == LAST_DIGIT) begin
                state_nx = CMD3;
              end else begin
                state_nx = DATA;
                cnt_nx   = cnt + CW'(1);
              end
            end
            default: state_nx = IDLE;
          endcase
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output decode from the next state so the registered strobe coincides with the issuing state.
  always_comb begin
    byte_d  = 8'h00;
    start_d = 1'b0;
    stop_d  = 1'b0;
    latch_d = 1'b0;
    busy_d  = (state_nx != IDLE);
    unique case (state_nx)
      CMD1: begin
        byte_d  = 8'h40;
        start_d = 1'b1;
        stop_d  = 1'b1;
        latch_d = 1'b1;
      end
      ADDR: begin
        byte_d  = 8'hC0;
        start_d = 1'b1;
        latch_d = 1'b1;
      end
      DATA: begin
        byte_d  = dig_byte[cnt_nx];
        stop_d  = (cnt_nx == LAST_DIGIT);
        latch_d = 1'b1;
      end
      CMD3: begin
        byte_d  = on_q ? {5'b10001, bright_q} : 8'h80;
        start_d = 1'b1;
        stop_d  = 1'b1;
        latch_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      tm_byte  <= 8'h00;
      tm_start <= 1'b0;
      tm_stop  <= 1'b0;
      tm_latch <= 1'b0;
    end else begin
      busy     <= busy_d;
      tm_byte  <= byte_d;
      tm_start <= start_d;
      tm_stop  <= stop_d;
      tm_latch <= latch_d;
    end
  end

endmodule

// File: tb/tb_hex_seq.sv
// Scoreboard bench for hex_seq (DIGITS=4) with a behavioural byte-driver busy model.
module tb_hex_seq;

  localparam int unsigned DIGITS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [4*DIGITS-1:0] data_in = '0;
  logic [DIGITS-1:0]   dp_in = '0;
  logic [2:0]          bright_in = '0;
  logic                disp_on = 1'b0;
  logic                data_latch = 1'b0;
  logic                busy;
  logic [7:0]          tm_byte;
  logic                tm_start;
  logic                tm_stop;
  logic                tm_latch;
  logic                tm_busy = 1'b0;

  typedef logic [9:0] exp_t;  // {start, stop, byte}
  exp_t sb[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;
  int n_lat = 0;
  int busy_len = 1;
  int bcnt = 0;
  bit pend = 1'b0;
  int base;

  hex_seq #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .bright_in  (bright_in),
    .disp_on    (disp_on),
    .data_latch (data_latch),
    .busy       (busy),
    .tm_byte    (tm_byte),
    .tm_start   (tm_start),
    .tm_stop    (tm_stop),
    .tm_latch   (tm_latch),
    .tm_busy    (tm_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte-driver model: busy rises the cycle after a strobe and stays up busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        tm_busy = 1'b0;
        bcnt    = 0;
        pend    = 1'b0;
      end else if (pend) begin
        pend    = 1'b0;
        tm_busy = 1'b1;
        bcnt    = busy_len;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) tm_busy = 1'b0;
      end
      if (rst && tm_latch === 1'b1) pend = 1'b1;
    end
  end

  // Monitor: every strobe pops one expected frame.
  initial begin
    forever begin
      @(negedge clk);
      if (tm_latch === 1'b1) begin
        n_lat++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got %0h with nothing expected", tm_byte);
        end else begin
          mon_e = sb.pop_front();
          chk("tm_frame", {22'd0, tm_start, tm_stop, tm_byte}, {22'd0, mon_e});
        end
      end
    end
  end

  task automatic push_seq(input logic [31:0] db, input logic [7:0] lastb);
    sb.push_back({2'b11, 8'h40});
    sb.push_back({2'b10, 8'hC0});
    sb.push_back({2'b00, db[31:24]});
    sb.push_back({2'b00, db[23:16]});
    sb.push_back({2'b00, db[15:8]});
    sb.push_back({2'b01, db[7:0]});
    sb.push_back({2'b11, lastb});
  endtask

  task automatic start_seq(input logic [15:0] d, input logic [3:0] dp, input logic [2:0] br,
                           input logic on, input logic [31:0] db, input logic [7:0] lastb);
    push_seq(db, lastb);
    @(negedge clk);
    data_in    = d;
    dp_in      = dp;
    bright_in  = br;
    disp_on    = on;
    data_latch = 1'b1;
    @(negedge clk);
    data_latch = 1'b0;
    chk("busy_after_capture", {31'd0, busy}, 32'd0);
    chk("latch_after_capture", {31'd0, tm_latch}, 32'd0);
    @(negedge clk);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    chk("first_latch", {31'd0, tm_latch}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("busy_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_seq(input logic [15:0] d, input logic [3:0] dp, input logic [2:0] br,
                         input logic on, input logic [31:0] db, input logic [7:0] lastb);
    start_seq(d, dp, br, on, db, lastb);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  task automatic wait_lat(input int target);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (n_lat >= target) break;
    end
    chk("reach_byte", n_lat, target);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached with %0d bytes seen", n_lat);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_latch", {31'd0, tm_latch}, 32'd0);
    chk("rst_start", {31'd0, tm_start}, 32'd0);
    chk("rst_stop", {31'd0, tm_stop}, 32'd0);
    chk("rst_byte", {24'd0, tm_byte}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    busy_len = 1;
    run_seq(16'hBEEF, 4'b0000, 3'd7, 1'b1, 32'h7C797971, 8'h8F);
    busy_len = 3;
`ifdef HEX_SEQ_LEADING_BLANK_EN
    run_seq(16'h0012, 4'b0000, 3'd3, 1'b1, 32'h0000065B, 8'h8B);
    run_seq(16'h0000, 4'b1000, 3'd0, 1'b1, 32'h8000003F, 8'h88);
    run_seq(16'h0456, 4'b0000, 3'd4, 1'b1, 32'h00666D7D, 8'h8C);
`else
    run_seq(16'h0012, 4'b0000, 3'd3, 1'b1, 32'h3F3F065B, 8'h8B);
    run_seq(16'h0000, 4'b1000, 3'd0, 1'b1, 32'hBF3F3F3F, 8'h88);
    run_seq(16'h0456, 4'b0000, 3'd4, 1'b1, 32'h3F666D7D, 8'h8C);
`endif
    busy_len = 2;
    run_seq(16'h1234, 4'b0100, 3'd2, 1'b0, 32'h06DB4F66, 8'h80);
    run_seq(16'h789A, 4'b0001, 3'd5, 1'b1, 32'h077F6FF7, 8'h8D);
    busy_len = 5;
    run_seq(16'hCDEF, 4'b1111, 3'd1, 1'b1, 32'hB9DEF9F1, 8'h89);

    // A capture request during DATA is dropped, not queued.
    busy_len = 2;
    base = n_lat;
    start_seq(16'h5678, 4'b0000, 3'd7, 1'b1, 32'h6D7D077F, 8'h8F);
    wait_lat(base + 3);
    data_in    = 16'h1111;
    data_latch = 1'b1;
    @(negedge clk);
    data_latch = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    chk("no_second_seq", n_lat, base + 7);
    chk("ignore_sb_drained", sb.size(), 32'd0);
    chk("ignore_busy_low", {31'd0, busy}, 32'd0);

    // Reset during the third DATA byte.
    base = n_lat;
    start_seq(16'hBEEF, 4'b0000, 3'd7, 1'b1, 32'h7C797971, 8'h8F);
    wait_lat(base + 5);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_latch", {31'd0, tm_latch}, 32'd0);
    chk("mid_rst_start", {31'd0, tm_start}, 32'd0);
    chk("mid_rst_stop", {31'd0, tm_stop}, 32'd0);
    chk("mid_rst_byte", {24'd0, tm_byte}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    base = n_lat;
    run_seq(16'hA5A5, 4'b0000, 3'd7, 1'b1, 32'h776D776D, 8'h8F);
    chk("post_rst_bytes", n_lat, base + 7);

    repeat (5) @(negedge clk);
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
